dplca_txop_table: RTL

- Writer side of the DPLCA TXOP occupancy table (Clause 148.4.7).
- Observes PLCA cycles, records which transmit opportunities are in use, and ages stale entries on each BEACON.
- Serves CLEAR_TXOP_TABLE, CLAIMING(nodeID), MAX_CLAIM and PICK_FREE_TXOP to the DPLCA control state diagram as registered outputs.

---
 rtl/dplca_pkg.sv | 15 +
 rtl/dplca_free_txop_pick.sv | 26 ++
 rtl/dplca_txop_table.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/dplca_pkg.sv
// Shared constants, FSM encoding and sizing helpers for the DPLCA TXOP occupancy table.
// Optional statistics output is enabled with `define DPLCA_TXOP_STATS_EN.
package dplca_pkg;

  localparam int DEF_ID_W = 8;
  localparam int COORD_ID = 0;

  localparam logic [0:0] ST_IDLE     = 1'b0;
  localparam logic [0:0] ST_CLEARING = 1'b1;

  function automatic int AGING_W(input int aging_cycles);
    return $clog2(aging_cycles + 1);
  endfunction

endpackage

// File: rtl/dplca_free_txop_pick.sv
// Combinational lowest-free TXOP finder; the coordinator ID is never offered.
module dplca_free_txop_pick
  import dplca_pkg::*;
#(
  parameter int NODE_CNT = 32,
  parameter int ID_W     = DEF_ID_W
) (
  input  logic [NODE_CNT-1:0] claimed,
  input  logic [ID_W-1:0]     limit,
  output logic                free_valid,
  output logic [ID_W-1:0]     free_txop
);

  // Scan downwards so the lowest qualifying ID is the last one assigned.
  always_comb begin
    free_valid = 1'b0;
    free_txop  = '0;
    for (int i = NODE_CNT - 1; i > COORD_ID; i--) begin
      if (!claimed[i] && (ID_W'(i) < limit)) begin
        free_valid = 1'b1;
        free_txop  = ID_W'(i);
      end
    end
  end

endmodule

// File: rtl/dplca_txop_table.sv
// DPLCA TXOP occupancy table: records active TXOPs, ages them on BEACON, answers claim queries.
// Define DPLCA_TXOP_STATS_EN to add the claimed_count output.
module dplca_txop_table
  import dplca_pkg::*;
#(
  parameter int NODE_CNT     = 32,
  parameter int AGING_CYCLES = 8,
  parameter int ID_W         = DEF_ID_W
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            beacon,
  input  logic            txop_end,
  input  logic [ID_W-1:0] txop_id,
  input  logic            txop_active,
  input  logic [ID_W-1:0] plca_node_count,
  input  logic            clear_req,
  output logic            clear_done,
  output logic            busy,
  input  logic            query_valid,
  input  logic [ID_W-1:0] query_id,
  output logic            claim_valid,
  output logic            claiming,
  output logic            max_claim,
  output logic            free_valid,
  output logic [ID_W-1:0] free_txop
`ifdef DPLCA_TXOP_STATS_EN
  ,
  output logic [ID_W-1:0] claimed_count
`endif
);

  localparam int AW    = AGING_W(AGING_CYCLES);
  localparam int PTR_W = (NODE_CNT > 1) ? $clog2(NODE_CNT) : 1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NODE_CNT - 1);

  logic [AW-1:0]     cnt_q [NODE_CNT];
  logic [AW-1:0]     cnt_d [NODE_CNT];
  logic [NODE_CNT-1:0] claimed;

  logic [0:0]        state_q, state_d;
  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic              armed_q, armed_d;
  logic              clear_done_q, clear_done_d;
  logic              claim_valid_q, claiming_q, claiming_d;
  logic              max_claim_q, free_valid_q;
  logic [ID_W-1:0]   free_txop_q;
  logic              pick_valid;
  logic [ID_W-1:0]   pick_txop;

  genvar gi;
  generate
    for (gi = 0; gi < NODE_CNT; gi++) begin : g_claimed
      assign claimed[gi] = (cnt_q[gi] != '0);
    end
  endgenerate

  // Clear sequencer; armed_q blocks a held clear_req from restarting a finished clear.
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    armed_d      = armed_q;
    clear_done_d = 1'b0;
    if (!clear_req) armed_d = 1'b1;
    case (state_q)
      ST_IDLE: begin
        if (clear_req && armed_q) begin
          state_d = ST_CLEARING;
          ptr_d   = '0;
          armed_d = 1'b0;
        end
      end
      ST_CLEARING: begin
        ptr_d = ptr_q + 1'b1;
        if (ptr_q == PTR_LAST) begin
          state_d      = ST_IDLE;
          ptr_d        = '0;
          clear_done_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Table next state: a fresh activity load overrides the beacon decrement.
  always_comb begin
    for (int i = 0; i < NODE_CNT; i++) begin
      cnt_d[i] = cnt_q[i];
      if (state_q == ST_CLEARING) begin
        if (ptr_q == PTR_W'(i)) cnt_d[i] = '0;
      end else begin
        if (beacon && (cnt_q[i] != '0)) cnt_d[i] = cnt_q[i] - 1'b1;
        if (txop_end && txop_active && (txop_id == ID_W'(i))) cnt_d[i] = AW'(AGING_CYCLES);
      end
    end
  end

  always_comb begin
    claiming_d = 1'b0;
    for (int i = 0; i < NODE_CNT; i++) begin
      if (query_valid && (query_id == ID_W'(i))) claiming_d = claimed[i];
    end
  end

  dplca_free_txop_pick #(
    .NODE_CNT (NODE_CNT),
    .ID_W     (ID_W)
  ) u_pick (
    .claimed    (claimed),
    .limit      (plca_node_count),
    .free_valid (pick_valid),
    .free_txop  (pick_txop)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NODE_CNT; i++) cnt_q[i] <= '0;
      state_q       <= ST_IDLE;
      ptr_q         <= '0;
      armed_q       <= 1'b1;
      clear_done_q  <= 1'b0;
      claim_valid_q <= 1'b0;
      claiming_q    <= 1'b0;
      max_claim_q   <= 1'b0;
      free_valid_q  <= 1'b0;
      free_txop_q   <= '0;
    end else begin
      for (int i = 0; i < NODE_CNT; i++) cnt_q[i] <= cnt_d[i];
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      armed_q       <= armed_d;
      clear_done_q  <= clear_done_d;
      claim_valid_q <= query_valid;
      claiming_q    <= claiming_d;
      max_claim_q   <= !pick_valid;
      free_valid_q  <= pick_valid;
      free_txop_q   <= pick_txop;
    end
  end

  assign clear_done  = clear_done_q;
  assign busy        = (state_q == ST_CLEARING);
  assign claim_valid = claim_valid_q;
  assign claiming    = claiming_q;
  assign max_claim   = max_claim_q;
  assign free_valid  = free_valid_q;
  assign free_txop   = free_txop_q;

`ifdef DPLCA_TXOP_STATS_EN
  logic [ID_W-1:0] claimed_count_q, claimed_count_d;

  always_comb begin
    claimed_count_d = '0;
    for (int i = COORD_ID + 1; i < NODE_CNT; i++) begin
      claimed_count_d = claimed_count_d + ID_W'(claimed[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) claimed_count_q <= '0;
    else       claimed_count_q <= claimed_count_d;
  end

  assign claimed_count = claimed_count_q;
`endif

endmodule
